// File: rtl/iic_req_arbiter_if.sv
// Request/response and engine bus of the two-client IIC request arbiter.
// Client i owns bit i of the 2-bit vectors and slice i of the packed fields.
interface iic_req_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    // Client request side
    logic [1:0]          req_valid;
    logic [1:0]          req_rw;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*DATA_W-1:0] req_wdata;
    logic [1:0]          req_ready;

    // Client response side
    logic [1:0]          rsp_done;
    logic [1:0]          rsp_err;
    logic [DATA_W-1:0]   rsp_rdata;
    logic                busy;

    // Shared IIC engine side
    logic                eng_write_en;
    logic                eng_read_en;
    logic [ADDR_W-1:0]   eng_addr;
    logic [DATA_W-1:0]   eng_wdata;
    logic                eng_done;
    logic [DATA_W-1:0]   eng_rdata;

    // Arbiter view
    modport slave (
        input  req_valid, req_rw, req_addr, req_wdata, eng_done, eng_rdata,
        output req_ready, rsp_done, rsp_err, rsp_rdata, busy,
               eng_write_en, eng_read_en, eng_addr, eng_wdata
    );

    // Clients plus engine view
    modport master (
        output req_valid, req_rw, req_addr, req_wdata, eng_done, eng_rdata,
        input  req_ready, rsp_done, rsp_err, rsp_rdata, busy,
               eng_write_en, eng_read_en, eng_addr, eng_wdata
    );
endinterface

// File: rtl/iic_req_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of the shared IIC engine.
// One transaction at a time: grant, start pulse, wait for done or timeout,
// then a one-cycle response to the granted client. All outputs registered.
module iic_req_arbiter #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic              s_clk,
    input  logic              s_rst,
    iic_req_arbiter_if.slave  arb
);

    // TIMEOUT_CYC >= 2, so the counter is at least one bit and never wraps
    // because it restarts from zero in ISSUE.
    localparam int              CNT_W    = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 32'sd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t             state_r;
    logic               grant_r;
    logic               last_grant_r;
    logic               rw_r;
    logic [CNT_W-1:0]   cnt_r;

    logic [1:0]         req_ready_r;
    logic [1:0]         rsp_done_r;
    logic [1:0]         rsp_err_r;
    logic [DATA_W-1:0]  rsp_rdata_r;
    logic               busy_r;
    logic               eng_write_en_r;
    logic               eng_read_en_r;
    logic [ADDR_W-1:0]  eng_addr_r;
    logic [DATA_W-1:0]  eng_wdata_r;

    logic               grant_s;
    logic               rw_sel_s;
    logic [ADDR_W-1:0]  addr_sel_s;
    logic [DATA_W-1:0]  wdata_sel_s;
    logic [1:0]         grant_onehot_s;
    logic [1:0]         sel_onehot_s;

    assign arb.req_ready    = req_ready_r;
    assign arb.rsp_done     = rsp_done_r;
    assign arb.rsp_err      = rsp_err_r;
    assign arb.rsp_rdata    = rsp_rdata_r;
    assign arb.busy         = busy_r;
    assign arb.eng_write_en = eng_write_en_r;
    assign arb.eng_read_en  = eng_read_en_r;
    assign arb.eng_addr     = eng_addr_r;
    assign arb.eng_wdata    = eng_wdata_r;

    assign grant_onehot_s = grant_r ? 2'b10 : 2'b01;
    assign sel_onehot_s   = grant_s ? 2'b10 : 2'b01;

    // Round-robin choice: a lone requester wins, a tie goes away from last_grant
    always_comb begin
        grant_s = 1'b0;
        case (arb.req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_grant_r;
            default: grant_s = 1'b0;
        endcase
    end

    // Pick the granted client's direction, address and write byte
    always_comb begin
        if (grant_s) begin
            rw_sel_s    = arb.req_rw[1];
            addr_sel_s  = arb.req_addr[ADDR_W +: ADDR_W];
            wdata_sel_s = arb.req_wdata[DATA_W +: DATA_W];
        end else begin
            rw_sel_s    = arb.req_rw[0];
            addr_sel_s  = arb.req_addr[0 +: ADDR_W];
            wdata_sel_s = arb.req_wdata[0 +: DATA_W];
        end
    end

    // Transaction sequencer; pulse outputs are set on entry to the state that owns them
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_r        <= ST_IDLE;
            grant_r        <= 1'b0;
            last_grant_r   <= 1'b1;
            rw_r           <= 1'b0;
            cnt_r          <= {CNT_W{1'b0}};
            req_ready_r    <= 2'b00;
            rsp_done_r     <= 2'b00;
            rsp_err_r      <= 2'b00;
            rsp_rdata_r    <= {DATA_W{1'b0}};
            busy_r         <= 1'b0;
            eng_write_en_r <= 1'b0;
            eng_read_en_r  <= 1'b0;
            eng_addr_r     <= {ADDR_W{1'b0}};
            eng_wdata_r    <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // eng_done is deliberately ignored here
                    if (arb.req_valid != 2'b00) begin
                        grant_r        <= grant_s;
                        rw_r           <= rw_sel_s;
                        eng_addr_r     <= addr_sel_s;
                        eng_wdata_r    <= wdata_sel_s;
                        req_ready_r    <= sel_onehot_s;
                        eng_read_en_r  <= rw_sel_s;
                        eng_write_en_r <= ~rw_sel_s;
                        busy_r         <= 1'b1;
                        state_r        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    // Accept and start pulses are visible for exactly this cycle
                    req_ready_r    <= 2'b00;
                    eng_write_en_r <= 1'b0;
                    eng_read_en_r  <= 1'b0;
                    cnt_r          <= {CNT_W{1'b0}};
                    state_r        <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Completion has priority over a timeout in the same cycle
                    if (arb.eng_done) begin
                        rsp_rdata_r <= rw_r ? arb.eng_rdata : {DATA_W{1'b0}};
                        rsp_err_r   <= 2'b00;
                        rsp_done_r  <= grant_onehot_s;
                        state_r     <= ST_RESP;
                    end else if (cnt_r == CNT_LAST) begin
                        rsp_rdata_r <= {DATA_W{1'b0}};
                        rsp_err_r   <= grant_onehot_s;
                        rsp_done_r  <= grant_onehot_s;
                        state_r     <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    // rsp_rdata keeps its value until the next capture
                    rsp_done_r   <= 2'b00;
                    rsp_err_r    <= 2'b00;
                    last_grant_r <= grant_r;
                    busy_r       <= 1'b0;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    req_ready_r    <= 2'b00;
                    rsp_done_r     <= 2'b00;
                    rsp_err_r      <= 2'b00;
                    eng_write_en_r <= 1'b0;
                    eng_read_en_r  <= 1'b0;
                    busy_r         <= 1'b0;
                    state_r        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
